// File: rtl/main_memory_model.sv
// Word-organised backing store behind the cache controller: fixed-latency
// read/write service with a one-cycle ready pulse and a sticky error flag.
module main_memory_model #(
  parameter int DEPTH   = 1024,
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_write_data,
  output logic [31:0] mem_read_data,
  output logic        mem_ready,
  output logic        mem_busy,
  output logic        mem_error
);

  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT_DROP} state_t;

  state_t              state;
  state_t              state_next;
  logic [CNT_W-1:0]    count;
  logic [ADDR_W-1:0]   index;
  logic [31:0]         wdata;
  logic                is_write;
  logic                request;
  logic                accept;
  logic                complete;
  logic [31:0]         mem [DEPTH];
  logic                unused_addr_bits;

  assign request  = mem_read | mem_write;
  assign mem_busy = (state != IDLE);
  // Upper address bits are deliberately discarded so addresses wrap.
  assign unused_addr_bits = &{1'b0, mem_address[31:ADDR_W+2]};

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    complete   = 1'b0;
    case (state)
      IDLE: begin
        if (request) begin
          accept     = 1'b1;
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        if (count == '0) begin
          complete   = 1'b1;
          state_next = WAIT_DROP;
        end
      end
      WAIT_DROP: begin
        if (!request) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      count         <= '0;
      index         <= '0;
      wdata         <= '0;
      is_write      <= 1'b0;
      mem_ready     <= 1'b0;
      mem_error     <= 1'b0;
      mem_read_data <= '0;
    end else begin
      state     <= state_next;
      mem_ready <= complete;
      if (accept) begin
        index    <= mem_address[ADDR_W+1:2];
        wdata    <= mem_write_data;
        is_write <= mem_write;
        count    <= CNT_W'(LATENCY - 1);
        if ((mem_read && mem_write) || (mem_address[1:0] != 2'b00))
          mem_error <= 1'b1;
      end else if (state == ACCESS && count != '0) begin
        count <= count - 1'b1;
      end
      if (complete && !is_write)
        mem_read_data <= mem[index];
    end
  end

  // A reset mid-access forces IDLE immediately, so no write fires afterwards.
  always_ff @(posedge clk) begin
    if (complete && is_write)
      mem[index] <= wdata;
  end

endmodule

// File: tb/tb_main_memory_model.sv
// Directed bench for main_memory_model: vector table of single accesses plus
// held-request and reset-mid-write sequences.
module tb_main_memory_model;

  logic        clk;
  logic        reset;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;
  logic        mem_ready;
  logic        mem_busy;
  logic        mem_error;

  int checks = 0;
  int errors = 0;

  main_memory_model #(.DEPTH(1024), .ADDR_W(10), .LATENCY(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_address   (mem_address),
    .mem_write_data(mem_write_data),
    .mem_read_data (mem_read_data),
    .mem_ready     (mem_ready),
    .mem_busy      (mem_busy),
    .mem_error     (mem_error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One access: request at a negedge, accepted at the following posedge,
  // inputs scrambled after acceptance, held `hold` cycles past ready, dropped.
  task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] data, input int hold,
                           output int lat, output int pulses, output int busy_drops);
    @(negedge clk);
    mem_read       = rd;
    mem_write      = wr;
    mem_address    = addr;
    mem_write_data = data;
    @(posedge clk); #1;
    mem_address    = addr ^ 32'h0000_0FF0;
    mem_write_data = ~data;
    lat        = 0;
    pulses     = 0;
    busy_drops = 0;
    if (!mem_busy) busy_drops++;
    while (lat < 50 && !mem_ready) begin
      @(posedge clk); #1;
      lat++;
      if (!mem_busy) busy_drops++;
    end
    if (mem_ready) pulses = 1;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (mem_ready) pulses++;
      if (!mem_busy) busy_drops++;
    end
    @(negedge clk);
    mem_read  = 1'b0;
    mem_write = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic run_and_check(input string tag, input logic rd, input logic wr,
                               input logic [31:0] addr, input logic [31:0] data, input int hold,
                               input logic [31:0] exp_rdata, input logic exp_err);
    int lat, pulses, bd;
    do_access(rd, wr, addr, data, hold, lat, pulses, bd);
    check({tag, " latency"}, lat, 4);
    check({tag, " ready_pulses"}, pulses, 1);
    check({tag, " busy_gaps"}, bd, 0);
    check({tag, " busy_after_drop"}, mem_busy, 0);
    check({tag, " rdata"}, mem_read_data, exp_rdata);
    check({tag, " error"}, mem_error, exp_err);
    $display("access %s rd=%0b wr=%0b addr=%h data=%h lat=%0d pulses=%0d rdata=%h err=%0b",
             tag, rd, wr, addr, data, lat, pulses, mem_read_data, mem_error);
  endtask

  initial begin
    int seen;

    vecs[0] = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 32'h0000_1004, 32'h1111_2222, 32'hDEAD_BEEF, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 32'h0000_0004, 32'h0000_0000, 32'h1111_2222, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 32'h0000_3FFC, 32'hCAFE_F00D, 32'h1111_2222, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 32'h0000_0FFC, 32'h0000_0000, 32'hCAFE_F00D, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 32'h0000_0006, 32'h0000_0000, 32'h1111_2222, 1'b1};
    vecs[7] = '{1'b1, 1'b1, 32'h0000_0020, 32'hA5A5_A5A5, 32'h1111_2222, 1'b1};
    vecs[8] = '{1'b1, 1'b0, 32'h0000_0020, 32'h0000_0000, 32'hA5A5_A5A5, 1'b1};

    reset          = 1'b0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_address    = '0;
    mem_write_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("reset ready", mem_ready, 0);
    check("reset busy", mem_busy, 0);
    check("reset error", mem_error, 0);
    check("reset rdata", mem_read_data, 32'h0);
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (mem_ready || mem_busy) seen++;
    end
    check("idle no activity", seen, 0);
    $display("reset/idle: ready=%0b busy=%0b err=%0b rdata=%h", mem_ready, mem_busy, mem_error, mem_read_data);

    for (int v = 0; v < 9; v++)
      run_and_check($sformatf("vec%0d", v), vecs[v].rd, vecs[v].wr, vecs[v].addr,
                    vecs[v].wdata, 0, vecs[v].exp_rdata, vecs[v].exp_err);

    // Held read: one pulse only, busy held throughout, then a fresh request.
    run_and_check("held_read", 1'b1, 1'b0, 32'h0000_0010, 32'h0, 10, 32'hDEAD_BEEF, 1'b1);
    run_and_check("after_held", 1'b1, 1'b0, 32'h0000_0020, 32'h0, 0, 32'hA5A5_A5A5, 1'b1);

    // Reset two cycles into a write must abandon it.
    run_and_check("preload", 1'b0, 1'b1, 32'h0000_0040, 32'h0BAD_F00D, 0, 32'hA5A5_A5A5, 1'b1);
    @(negedge clk);
    mem_write      = 1'b1;
    mem_address    = 32'h0000_0040;
    mem_write_data = 32'h1234_5678;
    @(posedge clk); #1;
    check("midwrite accepted busy", mem_busy, 1);
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("midwrite reset busy", mem_busy, 0);
    seen = 0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      if (mem_ready) seen++;
    end
    @(negedge clk);
    mem_write = 1'b0;
    reset     = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (mem_ready) seen++;
    end
    check("midwrite no ready", seen, 0);
    check("midwrite error cleared", mem_error, 0);
    check("midwrite rdata cleared", mem_read_data, 32'h0);
    $display("reset mid-write: ready pulses=%0d err=%0b rdata=%h", seen, mem_error, mem_read_data);
    run_and_check("read_after_abort", 1'b1, 1'b0, 32'h0000_0040, 32'h0, 0, 32'h0BAD_F00D, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
